// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM: steps each instruction through fetch/decode/execute/memory/writeback
// and counts retired instructions. Define MC_JAL_EN to compile in the JAL state.
module multicycle_controller #(
    parameter int INSTRET_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [6:0]           op,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 pc_write,
    output logic                 adr_src,
    output logic                 ir_write,
    output logic                 mem_write,
    output logic                 reg_write,
    output logic [1:0]           result_src,
    output logic [1:0]           alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           alu_op,
    output logic [1:0]           imm_src,
    output logic                 halted,
    output logic                 illegal,
    output logic                 retire,
    output logic [INSTRET_W-1:0] instret
);

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_HALT = 7'b0000000;
`ifdef MC_JAL_EN
    localparam logic [6:0] OP_JAL  = 7'b1101111;
`endif

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_HALT
`ifdef MC_JAL_EN
        , S_JAL
`endif
    } state_t;

    state_t                state_q, state_d;
    logic [INSTRET_W-1:0]  instret_q, instret_d;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

    assign instret = instret_q;

    // NOTE: every output gets a default before the case so no path leaves a latch behind.
    always_comb begin
        state_d    = state_q;
        pc_write   = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        imm_src    = 2'b00;
        halted     = 1'b0;
        illegal    = 1'b0;
        retire     = 1'b0;

        case (state_q)
            S_FETCH: begin
                result_src = 2'b10;
                alu_src_b  = 2'b10;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                // ALU precomputes the branch/jump target from old PC + immediate.
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                imm_src   = 2'b10;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_HALT:      state_d = S_HALT;
`ifdef MC_JAL_EN
                    OP_JAL: begin
                        imm_src = 2'b11;
                        state_d = S_JAL;
                    end
`endif
                    default: begin
                        illegal = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                imm_src   = (op == OP_SW) ? 2'b01 : 2'b00;
                state_d   = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                retire    = mem_ready;
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXECR: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
                state_d   = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_BEQ: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                pc_write  = zero;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
`ifdef MC_JAL_EN
            S_JAL: begin
                // PC takes the J-target held in ALU out while the ALU forms old PC + 4 for rd.
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_write  = 1'b1;
                state_d   = S_ALUWB;
            end
`endif
            S_HALT: halted = 1'b1;
            default: state_d = S_FETCH;
        endcase

        // FETCH is the reset state, so its mem_ready-gated strobes must also be blocked while rst_n is low.
        if (!rst_n) begin
            pc_write  = 1'b0;
            ir_write  = 1'b0;
            mem_write = 1'b0;
            reg_write = 1'b0;
            illegal   = 1'b0;
            retire    = 1'b0;
            halted    = 1'b0;
        end
    end

    always_comb begin
        instret_d = instret_q;
        if (retire) instret_d = instret_q + {{(INSTRET_W-1){1'b0}}, 1'b1};
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed and randomized instruction streams
// compared cycle by cycle against a per-instruction phase model built from the control table.
module tb_multicycle_controller;

    localparam int INSTRET_W = 32;
`ifdef MC_JAL_EN
    localparam bit JAL_EN = 1'b1;
`else
    localparam bit JAL_EN = 1'b0;
`endif

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_HALT = 7'b0000000;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [6:0]           op;
    logic                 zero;
    logic                 mem_ready;
    logic                 pc_write, adr_src, ir_write, mem_write, reg_write;
    logic [1:0]           result_src, alu_src_a, alu_src_b, alu_op, imm_src;
    logic                 halted, illegal, retire;
    logic [INSTRET_W-1:0] instret;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [INSTRET_W-1:0] model_instret = '0;

    always #5 clk = ~clk;

    multicycle_controller #(.INSTRET_W(INSTRET_W)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .adr_src(adr_src), .ir_write(ir_write), .mem_write(mem_write),
        .reg_write(reg_write), .result_src(result_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .imm_src(imm_src), .halted(halted),
        .illegal(illegal), .retire(retire), .instret(instret)
    );

    // Packed order: pc_write adr_src ir_write mem_write reg_write result_src alu_src_a alu_src_b alu_op imm_src halted illegal retire
    function automatic logic [17:0] mk(input bit pw, input bit as_, input bit irw, input bit mw, input bit rw,
                                       input logic [1:0] rs, input logic [1:0] sa, input logic [1:0] sb,
                                       input logic [1:0] ao, input logic [1:0] is_,
                                       input bit h, input bit il, input bit rt);
        return {pw, as_, irw, mw, rw, rs, sa, sb, ao, is_, h, il, rt};
    endfunction

    function automatic logic [17:0] observed();
        return {pc_write, adr_src, ir_write, mem_write, reg_write, result_src, alu_src_a,
                alu_src_b, alu_op, imm_src, halted, illegal, retire};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs are already driven (just after a rising edge); check mid-cycle, then advance one cycle.
    task automatic step(input logic [17:0] e, input string tag);
        @(negedge clk);
        check(tag, {14'd0, observed()}, {14'd0, e});
        @(posedge clk);
        #1;
    endtask

    // Runs one instruction from FETCH back to FETCH, with fst stall cycles in FETCH
    // and mst stall cycles in the data-memory phase.
    task automatic run_instr(input logic [6:0] opc, input int fst, input int mst, input bit z, input string tag);
        bit jal_ok, legal;
        jal_ok = JAL_EN && (opc == OP_JAL);
        legal  = (opc == OP_LW) || (opc == OP_SW) || (opc == OP_R) || (opc == OP_I) ||
                 (opc == OP_BEQ) || (opc == OP_HALT) || jal_ok;
        op   = opc;
        zero = z;
        for (int i = 0; i < fst; i++) begin
            mem_ready = 1'b0;
            step(mk(0,0,0,0,0, 2'b10,2'b00,2'b10,2'b00,2'b00, 0,0,0), {tag, ":fetch_stall"});
        end
        mem_ready = 1'b1;
        step(mk(1,0,1,0,0, 2'b10,2'b00,2'b10,2'b00,2'b00, 0,0,0), {tag, ":fetch"});
        mem_ready = 1'($urandom);
        step(mk(0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00, jal_ok ? 2'b11 : 2'b10, 0,!legal,0), {tag, ":decode"});
        if (!legal || opc == OP_HALT) begin
            check({tag, ":instret"}, instret, model_instret);
            return;
        end
        if (opc == OP_LW || opc == OP_SW) begin
            mem_ready = 1'($urandom);
            step(mk(0,0,0,0,0, 2'b00,2'b10,2'b01,2'b00, (opc == OP_SW) ? 2'b01 : 2'b00, 0,0,0), {tag, ":memadr"});
            for (int i = 0; i <= mst; i++) begin
                mem_ready = (i == mst);
                if (opc == OP_LW)
                    step(mk(0,1,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00, 0,0,0), {tag, ":memread"});
                else
                    step(mk(0,1,0,1,0, 2'b00,2'b00,2'b00,2'b00,2'b00, 0,0,i == mst), {tag, ":memwrite"});
            end
            if (opc == OP_LW) begin
                mem_ready = 1'($urandom);
                step(mk(0,0,0,0,1, 2'b01,2'b00,2'b00,2'b00,2'b00, 0,0,1), {tag, ":memwb"});
            end
        end else if (opc == OP_BEQ) begin
            mem_ready = 1'($urandom);
            step(mk(z,0,0,0,0, 2'b00,2'b10,2'b00,2'b01,2'b00, 0,0,1), {tag, ":beq"});
        end else begin
            mem_ready = 1'($urandom);
            if (opc == OP_R)
                step(mk(0,0,0,0,0, 2'b00,2'b10,2'b00,2'b10,2'b00, 0,0,0), {tag, ":execr"});
            else if (opc == OP_I)
                step(mk(0,0,0,0,0, 2'b00,2'b10,2'b01,2'b10,2'b00, 0,0,0), {tag, ":execi"});
            else
                step(mk(1,0,0,0,0, 2'b00,2'b01,2'b10,2'b00,2'b00, 0,0,0), {tag, ":jal"});
            mem_ready = 1'($urandom);
            step(mk(0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00,2'b00, 0,0,1), {tag, ":aluwb"});
        end
        model_instret = model_instret + 1;
        check({tag, ":instret"}, instret, model_instret);
    endtask

    initial begin
        logic [6:0] pool [8];
        pool = '{OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL, OP_LUI, 7'h7f};

        // Reset with mem_ready high: FETCH strobes must stay blocked.
        rst_n = 1'b0; op = OP_R; zero = 1'b0; mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset:outputs", {14'd0, observed()}, {14'd0, mk(0,0,0,0,0, 2'b10,2'b00,2'b10,2'b00,2'b00, 0,0,0)});
        check("reset:instret", instret, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Directed scenarios.
        run_instr(OP_R,    0, 0, 1'b0, "add");
        run_instr(OP_LW,   0, 2, 1'b0, "lw_stall2");
        run_instr(OP_SW,   0, 1, 1'b0, "sw_stall1");
        run_instr(OP_BEQ,  0, 0, 1'b1, "beq_taken");
        run_instr(OP_BEQ,  0, 0, 1'b0, "beq_not_taken");
        run_instr(OP_I,    2, 0, 1'b0, "addi_fetch_stall");
        run_instr(OP_JAL,  0, 0, 1'b0, "jal");
        run_instr(OP_LUI,  1, 0, 1'b0, "illegal_lui");

        // Randomized instruction stream.
        for (int n = 0; n < 60; n++) begin
            run_instr(pool[$urandom_range(0, 7)], $urandom_range(0, 2), $urandom_range(0, 3),
                      1'($urandom), "rand");
        end

        // Halt: halted from the third cycle, held regardless of mem_ready.
        run_instr(OP_HALT, 0, 0, 1'b0, "halt");
        for (int i = 0; i < 20; i++) begin
            mem_ready = 1'($urandom);
            op = 7'($urandom);
            step(mk(0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00, 1,0,0), "halt:hold");
        end
        check("halt:instret_kept", instret, model_instret);

        // Asynchronous reset mid-HALT, away from any clock edge.
        #2 rst_n = 1'b0; mem_ready = 1'b1;
        #1;
        check("halt_reset:halted", {31'd0, halted}, 32'd0);
        check("halt_reset:instret", instret, 32'd0);
        check("halt_reset:strobes", {27'd0, pc_write, ir_write, mem_write, reg_write, retire}, 32'd0);
        model_instret = '0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        op = OP_R;
        run_instr(OP_R, 0, 0, 1'b0, "add_after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
